// File: rtl/msm_fetch_pkg.sv
// msm_fetch_pkg: shared widths, FSM states and the fetched tuple layout for msm_point_fetch.
package msm_fetch_pkg;
    localparam int EC_BASE_FIELD_WIDTH = 377;
    localparam int EC_SCALAR_FIELD_WIDTH = 256;
    localparam int ADDR_WIDTH = 4;
    localparam int MEM_SIZE = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} fetch_state_e;

    typedef struct packed {
        logic [EC_BASE_FIELD_WIDTH-1:0] x;
        logic [EC_BASE_FIELD_WIDTH-1:0] y;
        logic [EC_BASE_FIELD_WIDTH-1:0] z;
        logic [EC_SCALAR_FIELD_WIDTH-1:0] k;
        logic [ADDR_WIDTH-1:0] index;
        logic last;
    } fetch_tuple_t;

    function automatic logic [ADDR_WIDTH:0] clamp_count(input logic [ADDR_WIDTH:0] n);
        logic [ADDR_WIDTH:0] lim;
        lim = MEM_SIZE[ADDR_WIDTH:0];
        return (n > lim) ? lim : n;
    endfunction
endpackage

// File: rtl/msm_fetch_fifo.sv
// msm_fetch_fifo: 2-entry synchronous FIFO with occupancy count; storage resets to zero.
module msm_fetch_fifo #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_q, rd_q, do_pop;
    logic [1:0]   count_q;

    assign do_pop  = pop_i && count_q != 2'd0;
    assign data_o  = mem_q[rd_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ~wr_q;
            end
            if (do_pop) rd_q <= ~rd_q;
            count_q <= count_q + 2'(push_i) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/msm_point_fetch.sv
// msm_point_fetch: walks indices 0..cnt-1 over the four point/scalar arrays and streams
// (x, y, z, k) tuples, keeping at most two tuples queued or in flight.
module msm_point_fetch
    import msm_fetch_pkg::*;
(
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic                             ap_start,
    input  logic [ADDR_WIDTH:0]              n_points,
    output logic                             ap_idle,
    output logic                             ap_done,
    output logic [ADDR_WIDTH-1:0]            P_arr_x_V_address0,
    output logic                             P_arr_x_V_ce0,
    output logic                             P_arr_x_V_we0,
    output logic [EC_BASE_FIELD_WIDTH-1:0]   P_arr_x_V_d0,
    input  logic [EC_BASE_FIELD_WIDTH-1:0]   P_arr_x_V_q0,
    output logic [ADDR_WIDTH-1:0]            P_arr_y_V_address0,
    output logic                             P_arr_y_V_ce0,
    output logic                             P_arr_y_V_we0,
    output logic [EC_BASE_FIELD_WIDTH-1:0]   P_arr_y_V_d0,
    input  logic [EC_BASE_FIELD_WIDTH-1:0]   P_arr_y_V_q0,
    output logic [ADDR_WIDTH-1:0]            P_arr_z_V_address0,
    output logic                             P_arr_z_V_ce0,
    output logic                             P_arr_z_V_we0,
    output logic [EC_BASE_FIELD_WIDTH-1:0]   P_arr_z_V_d0,
    input  logic [EC_BASE_FIELD_WIDTH-1:0]   P_arr_z_V_q0,
    output logic [ADDR_WIDTH-1:0]            K_arr_V_address0,
    output logic                             K_arr_V_ce0,
    output logic                             K_arr_V_we0,
    output logic [EC_SCALAR_FIELD_WIDTH-1:0] K_arr_V_d0,
    input  logic [EC_SCALAR_FIELD_WIDTH-1:0] K_arr_V_q0,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [EC_BASE_FIELD_WIDTH-1:0]   out_x,
    output logic [EC_BASE_FIELD_WIDTH-1:0]   out_y,
    output logic [EC_BASE_FIELD_WIDTH-1:0]   out_z,
    output logic [EC_SCALAR_FIELD_WIDTH-1:0] out_k,
    output logic [ADDR_WIDTH-1:0]            out_index,
    output logic                             out_last
);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    fetch_state_e          state_q;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d, rd_ptr_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  inflight_q, last_q, idle_q, done_q;
    logic [1:0]            fifo_count;
    logic                  pop, can_issue, issue, last_issue;
    fetch_tuple_t          push_data, head;

    assign cnt_d      = clamp_count(n_points);
    assign pop        = out_valid & out_ready;
    // Credit: queued + in-flight tuples, net of this cycle's pop, must leave room in the FIFO.
    assign can_issue  = ({1'b0, fifo_count} + 3'(inflight_q) - 3'(pop)) < 3'd2;
    assign issue      = state_q == S_RUN && can_issue;
    assign last_issue = rd_ptr_q == cnt_q - CNT_ONE;

    assign P_arr_x_V_address0 = rd_ptr_q[ADDR_WIDTH-1:0];
    assign P_arr_y_V_address0 = rd_ptr_q[ADDR_WIDTH-1:0];
    assign P_arr_z_V_address0 = rd_ptr_q[ADDR_WIDTH-1:0];
    assign K_arr_V_address0   = rd_ptr_q[ADDR_WIDTH-1:0];
    assign P_arr_x_V_ce0 = issue;
    assign P_arr_y_V_ce0 = issue;
    assign P_arr_z_V_ce0 = issue;
    assign K_arr_V_ce0   = issue;
    assign P_arr_x_V_we0 = 1'b0;
    assign P_arr_y_V_we0 = 1'b0;
    assign P_arr_z_V_we0 = 1'b0;
    assign K_arr_V_we0   = 1'b0;
    assign P_arr_x_V_d0  = '0;
    assign P_arr_y_V_d0  = '0;
    assign P_arr_z_V_d0  = '0;
    assign K_arr_V_d0    = '0;

    assign push_data = '{x: P_arr_x_V_q0, y: P_arr_y_V_q0, z: P_arr_z_V_q0,
                         k: K_arr_V_q0, index: idx_q, last: last_q};

    msm_fetch_fifo #(.W($bits(fetch_tuple_t))) u_fifo (
        .clk_i  (ap_clk),
        .rst_i  (ap_rst),
        .push_i (inflight_q),
        .data_i (push_data),
        .pop_i  (pop),
        .data_o (head),
        .count_o(fifo_count)
    );

    assign out_valid = fifo_count != 2'd0;
    assign out_x     = head.x;
    assign out_y     = head.y;
    assign out_z     = head.z;
    assign out_k     = head.k;
    assign out_index = head.index;
    assign out_last  = head.last;
    assign ap_idle   = idle_q;
    assign ap_done   = done_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= S_IDLE;
            idle_q     <= 1'b1;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            idx_q      <= '0;
            last_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            idle_q     <= 1'b0;
            done_q     <= 1'b0;
            if (issue) begin
                rd_ptr_q <= rd_ptr_q + CNT_ONE;
                idx_q    <= rd_ptr_q[ADDR_WIDTH-1:0];
                last_q   <= last_issue;
            end
            case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        cnt_q    <= cnt_d;
                        rd_ptr_q <= '0;
                        state_q  <= (cnt_d == '0) ? S_DONE : S_RUN;
                        done_q   <= cnt_d == '0;
                    end else begin
                        idle_q <= 1'b1;
                    end
                end
                S_RUN: if (issue && last_issue) state_q <= S_DRAIN;
                S_DRAIN: begin
                    if (fifo_count == 2'd0 && !inflight_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    idle_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msm_point_fetch.sv
// tb_msm_point_fetch: directed runs of msm_point_fetch against a registered-read array model,
// with a scoreboard of expected tuples checked as they leave the stream.
module tb_msm_point_fetch;
    import msm_fetch_pkg::*;
    localparam int EB = EC_BASE_FIELD_WIDTH;
    localparam int ES = EC_SCALAR_FIELD_WIDTH;
    localparam int AW = ADDR_WIDTH;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic          last;
    } exp_t;

    logic          ap_clk = 1'b0, ap_rst = 1'b1, ap_start = 1'b0, out_ready = 1'b0;
    logic [AW:0]   n_points = '0;
    logic          ap_idle, ap_done, out_valid, out_last;
    logic [AW-1:0] x_a, y_a, z_a, k_a, out_index;
    logic          x_ce, y_ce, z_ce, k_ce, x_we, y_we, z_we, k_we;
    logic [EB-1:0] x_d, y_d, z_d, x_q, y_q, z_q, out_x, out_y, out_z;
    logic [ES-1:0] k_d, k_q, out_k;

    int   checks = 0, errors = 0, issues = 0, pops = 0;
    int   last_addr = -1;
    logic we_seen = 1'b0, prev_stall = 1'b0;
    logic [AW-1:0] prev_idx;
    logic [EB-1:0] prev_x;
    logic [ES-1:0] prev_k;
    exp_t sb[$];

    always #5 ap_clk = ~ap_clk;

    msm_point_fetch dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .n_points(n_points),
        .ap_idle(ap_idle), .ap_done(ap_done),
        .P_arr_x_V_address0(x_a), .P_arr_x_V_ce0(x_ce), .P_arr_x_V_we0(x_we), .P_arr_x_V_d0(x_d), .P_arr_x_V_q0(x_q),
        .P_arr_y_V_address0(y_a), .P_arr_y_V_ce0(y_ce), .P_arr_y_V_we0(y_we), .P_arr_y_V_d0(y_d), .P_arr_y_V_q0(y_q),
        .P_arr_z_V_address0(z_a), .P_arr_z_V_ce0(z_ce), .P_arr_z_V_we0(z_we), .P_arr_z_V_d0(z_d), .P_arr_z_V_q0(z_q),
        .K_arr_V_address0(k_a), .K_arr_V_ce0(k_ce), .K_arr_V_we0(k_we), .K_arr_V_d0(k_d), .K_arr_V_q0(k_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_z(out_z),
        .out_k(out_k), .out_index(out_index), .out_last(out_last)
    );

    // Array contents: coordinate c at index i is c*0x100+i plus a marker in the top byte.
    function automatic logic [EB-1:0] fx(input int i, input int c);
        return (EB'(i + 1) << (EB - 8)) | EB'(c * 256 + i);
    endfunction

    function automatic logic [ES-1:0] fk(input int i);
        return (ES'(i + 1) << (ES - 8)) | ES'(i);
    endfunction

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Registered-read memories; output is junk whenever the read enable was low.
    always @(posedge ap_clk) begin
        x_q <= x_ce ? fx(int'(x_a), 1) : '1;
        y_q <= y_ce ? fx(int'(y_a), 2) : '1;
        z_q <= z_ce ? fx(int'(z_a), 3) : '1;
        k_q <= k_ce ? fk(int'(k_a)) : '1;
    end

    always @(negedge ap_clk) begin
        if (ap_rst) begin
            prev_stall = 1'b0;
            pops = issues;
        end else begin
            if (x_we | y_we | z_we | k_we) we_seen = 1'b1;
            if (x_ce) begin
                chk("credit", 384'((issues - pops - ((out_valid && out_ready) ? 1 : 0)) < 2), 384'(1));
                chk("ce_addr_match", {y_ce, z_ce, k_ce, y_a, z_a, k_a}, {3'b111, x_a, x_a, x_a});
                issues++;
                last_addr = int'(x_a);
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", {out_index, out_x, out_k}, {prev_idx, prev_x, prev_k});
            end
            if (out_valid && out_ready) begin
                chk("tuple_expected", 384'(sb.size() != 0), 384'(1));
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("index", out_index, e.idx);
                    chk("last", out_last, e.last);
                    chk("x", out_x, fx(int'(e.idx), 1));
                    chk("y", out_y, fx(int'(e.idx), 2));
                    chk("z", out_z, fx(int'(e.idx), 3));
                    chk("k", out_k, fk(int'(e.idx)));
                end
                pops++;
            end
            prev_stall = out_valid && !out_ready;
            prev_idx = out_index;
            prev_x = out_x;
            prev_k = out_k;
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_ctrl"}, {ap_idle, ap_done, x_ce, out_valid, out_last}, 5'b10000);
        chk({tag, "_addr"}, {x_a, out_index}, '0);
        chk({tag, "_data"}, {out_x, out_k}, '0);
    endtask

    // mode 0: ready held high, 1: ready toggles, 2: ready low for cycles 0..9.
    task automatic run(input int n, input int mode, input string tag);
        int cnt, t, fv, lv, dt, i0, p0;
        exp_t e;
        cnt = (n > MEM_SIZE) ? MEM_SIZE : n;
        for (int i = 0; i < cnt; i++) begin
            e.idx = AW'(i);
            e.last = (i == cnt - 1);
            sb.push_back(e);
        end
        i0 = issues; p0 = pops; fv = -1; lv = -1; dt = -1;
        out_ready = (mode != 2);
        n_points = (AW + 1)'(n);
        ap_start = 1'b1;
        tick();
        t = 1;
        while (dt < 0 && t < 200) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 2 == 1) : (t >= 10);
            ap_start = (mode == 0 && t == 2 && cnt > 0);
            if (mode == 0 && t == 1 && cnt > 0) chk({tag, "_first_issue"}, {x_ce, x_a}, {1'b1, AW'(0)});
            if (mode == 2 && t == 10) chk({tag, "_stalled_issues"}, issues - i0, 2);
            if (out_valid && fv < 0) fv = t;
            if (out_valid) lv = t;
            if (ap_done) dt = t;
            else begin
                tick();
                t++;
            end
        end
        ap_start = 1'b0;
        if (mode == 0) chk({tag, "_done_cycle"}, dt, (cnt == 0) ? 1 : cnt + 4);
        else chk({tag, "_done_seen"}, 384'(dt > 0), 384'(1));
        tick();
        chk({tag, "_done_pulse"}, {ap_done, ap_idle}, 2'b01);
        chk({tag, "_issues"}, issues - i0, cnt);
        chk({tag, "_pops"}, pops - p0, cnt);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        if (cnt > 0) chk({tag, "_last_addr"}, last_addr, cnt - 1);
        if (mode == 0) chk({tag, "_valid_window"}, {fv, lv}, (cnt == 0) ? {-32'sd1, -32'sd1} : {32'd3, 32'(cnt + 2)});
    endtask

    initial begin
        int anyv, dn;
        exp_t e;
        tick();
        tick();
        chk_reset("reset");
        ap_rst = 1'b0;
        tick();
        chk("idle_after_reset", ap_idle, 1);

        run(4, 0, "n4");
        run(16, 1, "n16_toggle");
        run(0, 0, "n0");
        run(20, 0, "n20_clamp");
        run(5, 2, "stall5");

        for (int i = 0; i < 8; i++) begin
            e.idx = AW'(i);
            e.last = (i == 7);
            sb.push_back(e);
        end
        out_ready = 1'b1;
        n_points = (AW + 1)'(8);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        chk_reset("mid_reset");
        sb.delete();
        anyv = 0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) anyv++;
            if (ap_done) dn++;
        end
        chk("mid_reset_no_valid", anyv, 0);
        chk("mid_reset_no_done", dn, 0);
        chk("mid_reset_idle", ap_idle, 1);
        run(2, 0, "post_reset");

        chk("we0_never", we_seen, 0);
        chk("d0_tied", {x_d, y_d, z_d, k_d}, '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
